stopwatch_timer: RTL and testbench

Parametrised run/pause/clear stopwatch with an internal tick prescaler, configurable minute limit, selectable saturate or wrap on overflow, and lap capture. It counts seconds 0..59 and minutes 0..MIN_LIMIT from a free-running system clock. It is intended as the timing core behind display and control logic in the puzzle and peripheral set.

---
 rtl/stopwatch_pkg.sv | 22 ++
 rtl/stopwatch_prescaler.sv | 36 +++
 rtl/stopwatch_timer.sv | 118 +++++++++++
 tb/tb_stopwatch_timer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch timer: state encoding, the last
// second value and a helper that sizes the tick prescaler.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int SEC_LAST = 59;

    // Prescaler width is clog2(div), never less than one bit so a
    // divide-by-one build still has a legal register.
    function automatic int presc_width(input int div);
        int w;
        w = $clog2(div);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/stopwatch_prescaler.sv
// Tick prescaler for the stopwatch: divides the system clock down to one
// tick per TICK_DIV enabled cycles. The count only advances while enabled,
// so a partially elapsed second survives a pause.
module stopwatch_prescaler
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = presc_width(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] count;

    assign tick = en && (count == LAST);

    // Advance while enabled, return to zero on the tick, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + W'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_timer.sv
// Run/pause/clear stopwatch counting seconds 0..59 and minutes
// 0..MIN_LIMIT, with saturate or wrap on overflow.
// Lap capture is built only when STOPWATCH_LAP_EN is defined; otherwise the
// lap input is ignored and the lap outputs are constant zero.
module stopwatch_timer
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV  = 4,
    parameter int SEC_W     = 6,
    parameter int MIN_W     = 7,
    parameter int MIN_LIMIT = 99,
    parameter int WRAP      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             lap,
    output logic [SEC_W-1:0] second,
    output logic [MIN_W-1:0] minute,
    output logic             running,
    output logic             overflow,
    output logic [SEC_W-1:0] lap_second,
    output logic [MIN_W-1:0] lap_minute,
    output logic             lap_valid
);

    localparam logic [SEC_W-1:0] SEC_MAX = SEC_W'(SEC_LAST);
    localparam logic [MIN_W-1:0] MIN_MAX = MIN_W'(MIN_LIMIT);

    state_t state;
    logic   run_en;
    logic   tick;

    assign run_en  = (state == RUN);
    assign running = run_en;

    stopwatch_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (run_en),
        .clr  (clear),
        .tick (tick)
    );

    // Control FSM plus the second/minute counters; the limit handling on a
    // tick is placed after the control case so a saturating hit lands in
    // DONE even if stop arrives in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state    <= IDLE;
            second   <= '0;
            minute   <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE:  if (start) state <= RUN;
                RUN:   if (stop)  state <= PAUSE;
                PAUSE: if (start) state <= RUN;
                DONE:  state <= DONE;
            endcase
            if (tick) begin
                if (second != SEC_MAX) begin
                    second <= second + SEC_W'(1);
                end else if (minute != MIN_MAX) begin
                    second <= '0;
                    minute <= minute + MIN_W'(1);
                end else begin
                    overflow <= 1'b1;
                    if (WRAP != 0) begin
                        second <= '0;
                        minute <= '0;
                    end else begin
                        state <= DONE;
                    end
                end
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic [SEC_W-1:0] lap_sec_q;
    logic [MIN_W-1:0] lap_min_q;
    logic             lap_valid_q;

    // Snapshot the pre-update count whenever the stopwatch is not idle;
    // the valid flag is a single-cycle pulse following the capture.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            lap_sec_q   <= '0;
            lap_min_q   <= '0;
            lap_valid_q <= 1'b0;
        end else begin
            lap_valid_q <= 1'b0;
            if (lap && (state != IDLE)) begin
                lap_sec_q   <= second;
                lap_min_q   <= minute;
                lap_valid_q <= 1'b1;
            end
        end
    end

    assign lap_second = lap_sec_q;
    assign lap_minute = lap_min_q;
    assign lap_valid  = lap_valid_q;
`else
    logic lap_unused;

    assign lap_unused = lap;
    assign lap_second = '0;
    assign lap_minute = '0;
    assign lap_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_timer.sv
// Testbench for stopwatch_timer. Three instances cover the main build
// (TICK_DIV=4, MIN_LIMIT=99, saturate) plus small-limit saturate and wrap
// builds at TICK_DIV=1. Expected outputs are queued as stimulus is applied
// and a separate monitor compares them on the falling edge.
module tb_stopwatch_timer;

`ifdef STOPWATCH_LAP_EN
    localparam int LAP_ON = 1;
`else
    localparam int LAP_ON = 0;
`endif

    localparam int DUT_A = 0;
    localparam int DUT_S = 1;
    localparam int DUT_W = 2;

    typedef struct {
        int sel;
        int sec;
        int min;
        int run;
        int ovf;
        int lsec;
        int lmin;
        int lv;
    } exp_t;

    logic       clk;
    logic [2:0] rstI;
    logic [2:0] startI;
    logic [2:0] stopI;
    logic [2:0] clearI;
    logic [2:0] lapI;

    logic [5:0] secO    [3];
    logic [6:0] minO    [3];
    logic       runO    [3];
    logic       ovfO    [3];
    logic [5:0] lapSecO [3];
    logic [6:0] lapMinO [3];
    logic       lapVO   [3];

    exp_t  expQ[$];
    string nameQ[$];
    int    vectors;
    int    miscompares;

    stopwatch_timer #(.TICK_DIV(4), .SEC_W(6), .MIN_W(7), .MIN_LIMIT(99), .WRAP(0)) dut_a (
        .clk(clk), .rst(rstI[0]), .start(startI[0]), .stop(stopI[0]), .clear(clearI[0]), .lap(lapI[0]),
        .second(secO[0]), .minute(minO[0]), .running(runO[0]), .overflow(ovfO[0]),
        .lap_second(lapSecO[0]), .lap_minute(lapMinO[0]), .lap_valid(lapVO[0])
    );

    stopwatch_timer #(.TICK_DIV(1), .SEC_W(6), .MIN_W(7), .MIN_LIMIT(2), .WRAP(0)) dut_s (
        .clk(clk), .rst(rstI[1]), .start(startI[1]), .stop(stopI[1]), .clear(clearI[1]), .lap(lapI[1]),
        .second(secO[1]), .minute(minO[1]), .running(runO[1]), .overflow(ovfO[1]),
        .lap_second(lapSecO[1]), .lap_minute(lapMinO[1]), .lap_valid(lapVO[1])
    );

    stopwatch_timer #(.TICK_DIV(1), .SEC_W(6), .MIN_W(7), .MIN_LIMIT(2), .WRAP(1)) dut_w (
        .clk(clk), .rst(rstI[2]), .start(startI[2]), .stop(stopI[2]), .clear(clearI[2]), .lap(lapI[2]),
        .second(secO[2]), .minute(minO[2]), .running(runO[2]), .overflow(ovfO[2]),
        .lap_second(lapSecO[2]), .lap_minute(lapMinO[2]), .lap_valid(lapVO[2])
    );

    // Free-running system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of control inputs on the selected instance, let the
    // rising edge sample them, then release them.
    task automatic applyStimulus(input int sel, input bit s, input bit p, input bit c, input bit l);
        startI[sel] = s;
        stopI[sel]  = p;
        clearI[sel] = c;
        lapI[sel]   = l;
        @(posedge clk);
        #1;
        startI[sel] = 1'b0;
        stopI[sel]  = 1'b0;
        clearI[sel] = 1'b0;
        lapI[sel]   = 1'b0;
    endtask

    // Let n rising edges pass with idle controls.
    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Queue the full expected output set for the selected instance.
    task automatic checkOutput(input int sel, input string name, input int sec, input int min,
                               input int run, input int ovf, input int lsec, input int lmin,
                               input int lv);
        exp_t e;
        e.sel  = sel;
        e.sec  = sec;
        e.min  = min;
        e.run  = run;
        e.ovf  = ovf;
        e.lsec = lsec;
        e.lmin = lmin;
        e.lv   = lv;
        expQ.push_back(e);
        nameQ.push_back(name);
    endtask

    // Shorthand for checks where the lap registers are expected at zero.
    task automatic checkCount(input int sel, input string name, input int sec, input int min,
                              input int run, input int ovf);
        checkOutput(sel, name, sec, min, run, ovf, 0, 0, 0);
    endtask

    // Monitor: compare every queued expectation against the live outputs
    // on the falling edge, away from the sampling edge.
    initial begin
        exp_t  e;
        string nm;
        int    aSec, aMin, aRun, aOvf, aLs, aLm, aLv;
        forever begin
            @(negedge clk);
            while (expQ.size() > 0) begin
                e  = expQ.pop_front();
                nm = nameQ.pop_front();
                aSec = int'(secO[e.sel]);
                aMin = int'(minO[e.sel]);
                aRun = int'(runO[e.sel]);
                aOvf = int'(ovfO[e.sel]);
                aLs  = int'(lapSecO[e.sel]);
                aLm  = int'(lapMinO[e.sel]);
                aLv  = int'(lapVO[e.sel]);
                vectors++;
                if (aSec != e.sec || aMin != e.min || aRun != e.run || aOvf != e.ovf ||
                    aLs != e.lsec || aLm != e.lmin || aLv != e.lv) begin
                    miscompares++;
                    $display("[TB] FAIL %s: got %0d:%0d run=%0d ovf=%0d lap=%0d:%0d lv=%0d, want %0d:%0d run=%0d ovf=%0d lap=%0d:%0d lv=%0d",
                             nm, aMin, aSec, aRun, aOvf, aLm, aLs, aLv,
                             e.min, e.sec, e.run, e.ovf, e.lmin, e.lsec, e.lv);
                end
            end
        end
    end

    // Directed stimulus sequence.
    initial begin
        int drain;
        vectors     = 0;
        miscompares = 0;
        rstI   = 3'b111;
        startI = '0;
        stopI  = '0;
        clearI = '0;
        lapI   = '0;
        stepCycles(2);
        rstI = 3'b000;
        checkCount(DUT_A, "reset_a", 0, 0, 0, 0);
        checkCount(DUT_S, "reset_s", 0, 0, 0, 0);
        checkCount(DUT_W, "reset_w", 0, 0, 0, 0);

        // Basic counting at TICK_DIV=4 and the 0:59 -> 1:00 rollover.
        applyStimulus(DUT_A, 1, 0, 0, 0);
        checkCount(DUT_A, "start_running", 0, 0, 1, 0);
        stepCycles(3);
        checkCount(DUT_A, "before_first_tick", 0, 0, 1, 0);
        stepCycles(1);
        checkCount(DUT_A, "first_second", 1, 0, 1, 0);
        stepCycles(4);
        checkCount(DUT_A, "second_two", 2, 0, 1, 0);
        stepCycles(228);
        checkCount(DUT_A, "at_0_59", 59, 0, 1, 0);
        stepCycles(4);
        checkCount(DUT_A, "minute_roll", 0, 1, 1, 0);

        // Clear, then a pause that must preserve the partial second.
        applyStimulus(DUT_A, 0, 0, 1, 0);
        checkCount(DUT_A, "clear_idle", 0, 0, 0, 0);
        applyStimulus(DUT_A, 1, 0, 0, 0);
        stepCycles(1);
        applyStimulus(DUT_A, 0, 1, 0, 0);
        checkCount(DUT_A, "paused", 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            stepCycles(1);
            if (i == 4 || i == 9) checkCount(DUT_A, "pause_hold", 0, 0, 0, 0);
        end
        applyStimulus(DUT_A, 1, 0, 0, 0);
        checkCount(DUT_A, "resume", 0, 0, 1, 0);
        stepCycles(1);
        checkCount(DUT_A, "resume_plus1", 0, 0, 1, 0);
        stepCycles(1);
        checkCount(DUT_A, "resume_plus2", 1, 0, 1, 0);

        // Lap coincident with the 0:07 -> 0:08 tick.
        stepCycles(27);
        checkCount(DUT_A, "at_0_07", 7, 0, 1, 0);
        applyStimulus(DUT_A, 0, 0, 0, 1);
        checkOutput(DUT_A, "lap_capture", 8, 0, 1, 0, 7 * LAP_ON, 0, LAP_ON);
        stepCycles(1);
        checkOutput(DUT_A, "lap_pulse_end", 8, 0, 1, 0, 7 * LAP_ON, 0, 0);

        // start+stop+clear+lap together at 1:30 -> clear wins.
        stepCycles(327);
        checkOutput(DUT_A, "at_1_30", 30, 1, 1, 0, 7 * LAP_ON, 0, 0);
        applyStimulus(DUT_A, 1, 1, 1, 1);
        checkCount(DUT_A, "combo_clear", 0, 0, 0, 0);
        stepCycles(5);
        checkCount(DUT_A, "combo_stays_idle", 0, 0, 0, 0);
        applyStimulus(DUT_A, 0, 0, 0, 1);
        stepCycles(1);
        checkCount(DUT_A, "lap_idle_ignored", 0, 0, 0, 0);

        // Saturating limit at MIN_LIMIT=2.
        applyStimulus(DUT_S, 1, 0, 0, 0);
        checkCount(DUT_S, "sat_start", 0, 0, 1, 0);
        stepCycles(1);
        checkCount(DUT_S, "sat_div1_tick", 1, 0, 1, 0);
        stepCycles(178);
        checkCount(DUT_S, "sat_2_59", 59, 2, 1, 0);
        stepCycles(1);
        checkCount(DUT_S, "sat_hold", 59, 2, 0, 1);
        stepCycles(3);
        checkCount(DUT_S, "sat_hold_later", 59, 2, 0, 1);
        applyStimulus(DUT_S, 1, 0, 0, 0);
        checkCount(DUT_S, "done_ignores_start", 59, 2, 0, 1);
        applyStimulus(DUT_S, 0, 0, 1, 0);
        checkCount(DUT_S, "done_clear", 0, 0, 0, 0);
        applyStimulus(DUT_S, 1, 0, 0, 0);
        checkCount(DUT_S, "restart_after_clear", 0, 0, 1, 0);

        // Wrapping limit at MIN_LIMIT=2.
        applyStimulus(DUT_W, 1, 0, 0, 0);
        stepCycles(59);
        checkCount(DUT_W, "wrap_0_59", 59, 0, 1, 0);
        stepCycles(1);
        checkCount(DUT_W, "wrap_1_00", 0, 1, 1, 0);
        stepCycles(119);
        checkCount(DUT_W, "wrap_2_59", 59, 2, 1, 0);
        stepCycles(1);
        checkCount(DUT_W, "wrap_roll", 0, 0, 1, 1);
        stepCycles(1);
        checkCount(DUT_W, "wrap_keeps_running", 1, 0, 1, 1);

        // Let the monitor drain the queue, bounded.
        drain = 0;
        while (expQ.size() > 0 && drain < 10) begin
            @(negedge clk);
            #1;
            drain++;
        end
        if (expQ.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d expectations left, want 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
